// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: the fetch FSM state
// type and the instruction width in bytes.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        FAULT  = 2'd2
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_word_read.sv
// Combinational instruction word read: turns a byte address into four
// byte indices into the instruction memory and assembles them little-endian.
// Indices always come from the word-aligned address and wrap modulo the
// memory depth, so an out-of-range address never indexes past the array.
module fetch_word_read
    import mips_fetch_pkg::*;
#(
    parameter int MEM_BYTES = 256
) (
    input  logic [7:0]  mem_i [MEM_BYTES],
    input  logic [31:0] pc_i,
    output logic [31:0] word_o
);

    localparam int          IDX_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam logic [31:0] DEPTH = 32'(MEM_BYTES);

    logic [31:0] wordBase;

    assign wordBase = pc_i & 32'hFFFF_FFFC;

    // One byte lane per instruction byte; lane k lands in bits [8k+7:8k].
    for (genvar k = 0; k < INSTR_BYTES; k++) begin : g_byte
        logic [IDX_W-1:0] byteIdx;
        assign byteIdx              = IDX_W'((wordBase + 32'(k)) % DEPTH);
        assign word_o[8*k +: 8]     = mem_i[byteIdx];
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage with a one-entry output register, valid/ready
// handshake toward decode, redirect from execute and a handshake counter.
// Optional feature: define FETCH_BOUNDS_CHECK_EN to trap misaligned or
// out-of-range fetch addresses into a sticky FAULT state (left only by reset).
// Without it, addresses wrap into the memory and fault stays low.
module instr_fetch
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  instruction_mem [MEM_BYTES],
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic [31:0] instr_count,
    output logic        fault
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         outValid_q, outValid_d;
    logic [31:0]  outInstr_q, outInstr_d;
    logic [31:0]  outPc_q, outPc_d;
    logic [31:0]  instrCount_q, instrCount_d;
    logic         fault_q, fault_d;

    logic [31:0]  fetchWord;
    logic         pcBad;
    logic         canAdvance;
    logic         handshake;

    fetch_word_read #(
        .MEM_BYTES (MEM_BYTES)
    ) u_word_read (
        .mem_i  (instruction_mem),
        .pc_i   (pc_q),
        .word_o (fetchWord)
    );

    assign handshake  = outValid_q & out_ready;
    assign canAdvance = ~outValid_q | out_ready;

`ifdef FETCH_BOUNDS_CHECK_EN
    // 33-bit compare so a pc near the top of the address space cannot wrap past the check.
    assign pcBad = (pc_q[1:0] != 2'b00) ||
                   (({1'b0, pc_q} + 33'd3) >= 33'(MEM_BYTES));
`else
    assign pcBad = 1'b0;
`endif

    // Next-state logic: redirect beats everything, otherwise advance unless decode is stalling us.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        outValid_d   = outValid_q;
        outInstr_d   = outInstr_q;
        outPc_d      = outPc_q;
        fault_d      = fault_q;
        instrCount_d = instrCount_q + {31'd0, handshake};
        case (state_q)
            RUN, BUBBLE: begin
                if (redirect_valid) begin
                    pc_d       = redirect_pc;
                    outValid_d = 1'b0;
                    state_d    = BUBBLE;
                end else if (canAdvance) begin
                    if (pcBad) begin
                        state_d    = FAULT;
                        fault_d    = 1'b1;
                        outValid_d = 1'b0;
                    end else begin
                        outInstr_d = fetchWord;
                        outPc_d    = pc_q;
                        outValid_d = 1'b1;
                        pc_d       = pc_q + 32'd4;
                        state_d    = RUN;
                    end
                end
            end
            FAULT: begin
                outValid_d = 1'b0;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State and output registers, cleared asynchronously so a reset drops any in-flight fetch or redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            outValid_q   <= 1'b0;
            outInstr_q   <= 32'd0;
            outPc_q      <= 32'd0;
            instrCount_q <= 32'd0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            outValid_q   <= outValid_d;
            outInstr_q   <= outInstr_d;
            outPc_q      <= outPc_d;
            instrCount_q <= instrCount_d;
            fault_q      <= fault_d;
        end
    end

    assign out_valid    = outValid_q;
    assign out_instr    = outInstr_q;
    assign out_pc       = outPc_q;
    assign out_pc_plus4 = outPc_q + 32'd4;
    assign instr_count  = instrCount_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by a
// randomized run compared against a behavioural model of the fetch stage.
// Expectations follow FETCH_BOUNDS_CHECK_EN when it is defined.
module tb_instr_fetch;

    localparam int          MEM_BYTES = 256;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  mem [MEM_BYTES];
    logic        redirectValid = 1'b0;
    logic [31:0] redirectPc = 32'd0;
    logic        outReady = 1'b0;
    logic        outValid;
    logic [31:0] outInstr;
    logic [31:0] outPc;
    logic [31:0] outPcPlus4;
    logic [31:0] instrCount;
    logic        fault;

    int checks = 0;
    int errors = 0;

    // Behavioural model: what decode should currently see
    logic [31:0] mPc;
    logic [31:0] mInstr;
    logic [31:0] mOutPc;
    logic [31:0] mCount;
    bit          mValid;
    bit          mFaulted;

    instr_fetch #(
        .RESET_PC  (RESET_PC),
        .MEM_BYTES (MEM_BYTES)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .instruction_mem (mem),
        .redirect_valid  (redirectValid),
        .redirect_pc     (redirectPc),
        .out_ready       (outReady),
        .out_valid       (outValid),
        .out_instr       (outInstr),
        .out_pc          (outPc),
        .out_pc_plus4    (outPcPlus4),
        .instr_count     (instrCount),
        .fault           (fault)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    function automatic logic [31:0] refWord(input logic [31:0] addr);
        logic [31:0] w;
        longint      a;
        w = 32'd0;
        a = longint'(addr) - longint'(addr % 4);
        for (int k = 0; k < 4; k++) w[8*k +: 8] = mem[int'((a + k) % MEM_BYTES)];
        return w;
    endfunction

    function automatic bit refBad(input logic [31:0] addr);
`ifdef FETCH_BOUNDS_CHECK_EN
        return (addr % 4 != 0) || (longint'(addr) + 3 >= MEM_BYTES);
`else
        return (addr === 32'hxxxx_xxxx);
`endif
    endfunction

    task automatic modelReset();
        mPc      = RESET_PC;
        mInstr   = 32'd0;
        mOutPc   = 32'd0;
        mCount   = 32'd0;
        mValid   = 1'b0;
        mFaulted = 1'b0;
    endtask

    task automatic modelStep();
        if (!mFaulted) begin
            if (mValid && outReady) mCount = mCount + 32'd1;
            if (redirectValid) begin
                mPc    = redirectPc;
                mValid = 1'b0;
            end else if (!mValid || outReady) begin
                if (refBad(mPc)) begin
                    mFaulted = 1'b1;
                    mValid   = 1'b0;
                end else begin
                    mInstr = refWord(mPc);
                    mOutPc = mPc;
                    mValid = 1'b1;
                    mPc    = mPc + 32'd4;
                end
            end
        end
    endtask

    task automatic cycle();
        if (!reset) modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        modelReset();
        cycle();
        cycle();
        checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", outValid); end
        checks++; if (outInstr !== 32'd0) begin errors++; $display("[TB] FAIL reset_instr got %h expected 0", outInstr); end
        checks++; if (outPc !== 32'd0) begin errors++; $display("[TB] FAIL reset_pc got %h expected 0", outPc); end
        checks++; if (instrCount !== 32'd0) begin errors++; $display("[TB] FAIL reset_count got %0d expected 0", instrCount); end
        checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault got %b expected 0", fault); end
    endtask

    task automatic test_first_fetch();
        outReady = 1'b1;
        reset    = 1'b0;
        cycle();
        checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL first_valid got %b expected 1", outValid); end
        checks++; if (outInstr !== 32'h200A_000A) begin errors++; $display("[TB] FAIL first_instr got %h expected 200a000a", outInstr); end
        checks++; if (outPc !== 32'd0) begin errors++; $display("[TB] FAIL first_pc got %h expected 0", outPc); end
        checks++; if (outPcPlus4 !== 32'd4) begin errors++; $display("[TB] FAIL first_pc4 got %h expected 4", outPcPlus4); end
    endtask

    task automatic test_stall();
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (outInstr !== 32'h200A_000A || outPc !== 32'd0 || outValid !== 1'b1) begin
                errors++; $display("[TB] FAIL stall_hold got %h/%h/%b expected 200a000a/0/1", outInstr, outPc, outValid);
            end
            checks++; if (instrCount !== 32'd0) begin errors++; $display("[TB] FAIL stall_count got %0d expected 0", instrCount); end
        end
        outReady = 1'b1;
        cycle();
        checks++; if (instrCount !== 32'd1) begin errors++; $display("[TB] FAIL release_count got %0d expected 1", instrCount); end
        checks++; if (outPc !== 32'd4 || outInstr !== 32'h0706_0504) begin
            errors++; $display("[TB] FAIL release_fetch got %h/%h expected 4/07060504", outPc, outInstr);
        end
    endtask

    task automatic test_redirect();
        outReady      = 1'b0;
        redirectValid = 1'b1;
        redirectPc    = 32'h40;
        cycle();
        checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL redirect_flush got %b expected 0", outValid); end
        checks++; if (instrCount !== 32'd1) begin errors++; $display("[TB] FAIL redirect_count got %0d expected 1", instrCount); end
        redirectValid = 1'b0;
        cycle();
        checks++; if (outValid !== 1'b1 || outPc !== 32'h40) begin
            errors++; $display("[TB] FAIL redirect_target got %b/%h expected 1/40", outValid, outPc);
        end
        checks++; if (outInstr !== 32'h4342_4140) begin errors++; $display("[TB] FAIL redirect_instr got %h expected 43424140", outInstr); end
    endtask

    task automatic test_reset_mid();
        pulseReset();
        outReady = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        checks++; if (outPc !== 32'h10 || instrCount !== 32'd4) begin
            errors++; $display("[TB] FAIL stream_setup got %h/%0d expected 10/4", outPc, instrCount);
        end
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        checks++; if (outValid !== 1'b0 || instrCount !== 32'd0) begin
            errors++; $display("[TB] FAIL async_reset got %b/%0d expected 0/0", outValid, instrCount);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle();
        checks++; if (outValid !== 1'b1 || outPc !== RESET_PC) begin
            errors++; $display("[TB] FAIL after_reset got %b/%h expected 1/%h", outValid, outPc, RESET_PC);
        end
    endtask

    task automatic test_bad_redirect();
        outReady      = 1'b1;
        redirectValid = 1'b1;
        redirectPc    = 32'h102;
        cycle();
        checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL bad_bubble got %b expected 0", outValid); end
        redirectValid = 1'b0;
        cycle();
`ifdef FETCH_BOUNDS_CHECK_EN
        checks++; if (fault !== 1'b1 || outValid !== 1'b0) begin
            errors++; $display("[TB] FAIL bad_fault got %b/%b expected 1/0", fault, outValid);
        end
`else
        checks++; if (outValid !== 1'b1 || outPc !== 32'h102 || outInstr !== 32'h200A_000A || fault !== 1'b0) begin
            errors++; $display("[TB] FAIL bad_wrapfetch got %b/%h/%h/%b expected 1/102/200a000a/0", outValid, outPc, outInstr, fault);
        end
`endif
        redirectValid = 1'b1;
        redirectPc    = 32'h0;
        cycle();
        redirectValid = 1'b0;
        cycle();
`ifdef FETCH_BOUNDS_CHECK_EN
        checks++; if (fault !== 1'b1 || outValid !== 1'b0) begin
            errors++; $display("[TB] FAIL fault_sticky got %b/%b expected 1/0", fault, outValid);
        end
`else
        checks++; if (outValid !== 1'b1 || outPc !== 32'h0 || outInstr !== 32'h200A_000A) begin
            errors++; $display("[TB] FAIL second_redirect got %b/%h/%h expected 1/0/200a000a", outValid, outPc, outInstr);
        end
`endif
        pulseReset();
    endtask

    task automatic test_wrap();
        outReady      = 1'b1;
        redirectValid = 1'b1;
        redirectPc    = 32'hFC;
        cycle();
        redirectValid = 1'b0;
        cycle();
        checks++; if (outPc !== 32'hFC || outInstr !== 32'hFFFE_FDFC || outPcPlus4 !== 32'h100) begin
            errors++; $display("[TB] FAIL top_fetch got %h/%h/%h expected fc/fffefdfc/100", outPc, outInstr, outPcPlus4);
        end
        cycle();
`ifdef FETCH_BOUNDS_CHECK_EN
        checks++; if (fault !== 1'b1 || outValid !== 1'b0) begin
            errors++; $display("[TB] FAIL wrap_fault got %b/%b expected 1/0", fault, outValid);
        end
`else
        checks++; if (outPc !== 32'h100 || outInstr !== 32'h200A_000A || outPcPlus4 !== 32'h104 || fault !== 1'b0) begin
            errors++; $display("[TB] FAIL wrap_fetch got %h/%h/%h/%b expected 100/200a000a/104/0", outPc, outInstr, outPcPlus4, fault);
        end
`endif
        pulseReset();
    endtask

    task automatic test_random();
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);
        pulseReset();
        for (int n = 0; n < 3000; n++) begin
            if (mFaulted || $urandom_range(199) == 0) pulseReset();
            outReady      = ($urandom_range(3) != 0);
            redirectValid = ($urandom_range(7) == 0);
            case ($urandom_range(3))
                0:       redirectPc = $urandom;
                1:       redirectPc = 32'hFFFF_FFFC;
                default: redirectPc = 32'($urandom_range(63)) * 32'd4;
            endcase
            cycle();
            checks++; if (outValid !== mValid) begin
                errors++; $display("[TB] FAIL rand_valid cycle %0d got %b expected %b", n, outValid, mValid);
            end
            if (mValid) begin
                checks++; if (outInstr !== mInstr || outPc !== mOutPc) begin
                    errors++; $display("[TB] FAIL rand_fetch cycle %0d got %h/%h expected %h/%h", n, outInstr, outPc, mInstr, mOutPc);
                end
                checks++; if (outPcPlus4 !== mOutPc + 32'd4) begin
                    errors++; $display("[TB] FAIL rand_pc4 cycle %0d got %h expected %h", n, outPcPlus4, mOutPc + 32'd4);
                end
            end
            checks++; if (instrCount !== mCount) begin
                errors++; $display("[TB] FAIL rand_count cycle %0d got %0d expected %0d", n, instrCount, mCount);
            end
            checks++; if (fault !== mFaulted) begin
                errors++; $display("[TB] FAIL rand_fault cycle %0d got %b expected %b", n, fault, mFaulted);
            end
        end
        redirectValid = 1'b0;
    endtask

    // Scenario sequence: directed cases first, then the randomized run
    initial begin
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'(i);
        mem[0] = 8'h0A;
        mem[1] = 8'h00;
        mem[2] = 8'h0A;
        mem[3] = 8'h20;
        modelReset();
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect();
        test_reset_mid();
        test_bad_redirect();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
